// File: rtl/gcm_block_dispatcher.sv
// Central block sequencer for the parallel AES-GCM workers: takes one frame header,
// then streams its 128-bit blocks round-robin to the workers with counter/phase/flag tags.
module gcm_block_dispatcher #(
   parameter int N_WORKERS  = 4,
   parameter int MAX_BLOCKS = 100000,
   parameter int CNT_W      = 17
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_hdr_valid,
   output logic                 o_hdr_ready,
   input  logic [63:0]          i_hdr_aad_bits,
   input  logic [63:0]          i_hdr_pt_bits,
   input  logic [95:0]          i_hdr_iv,
   input  logic                 i_blk_valid,
   output logic                 o_blk_ready,
   input  logic [127:0]         i_blk_data,
   output logic [N_WORKERS-1:0] o_disp_valid,
   input  logic [N_WORKERS-1:0] i_disp_ready,
   output logic [127:0]         o_disp_data,
   output logic [95:0]          o_disp_iv,
   output logic [CNT_W-1:0]     o_disp_counter,
   output logic [2:0]           o_disp_phase,
   output logic                 o_disp_new_instance,
   output logic                 o_disp_last,
   output logic                 o_busy,
   output logic                 o_hdr_err
);

   localparam int          SEL_W     = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;
   localparam logic [64:0] MAX_BLK_C = 65'(MAX_BLOCKS);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CHECK  = 2'd1,
      ST_STREAM = 2'd2,
      ST_DRAIN  = 2'd3
   } state_t;

   state_t               state_r;
   state_t               state_nxt_s;

   // Block counts are kept at 65 bits so a 64-bit length can never wrap into a legal size.
   logic [64:0]          aad_blk_s;
   logic [64:0]          pt_blk_s;
   logic [64:0]          tot_s;
   logic [64:0]          aad_blk_r;
   logic [64:0]          pt_blk_r;
   logic [64:0]          tot_r;
   logic [64:0]          idx_ext_s;
   logic [95:0]          iv_r;
   logic [CNT_W-1:0]     idx_r;

   logic                 hdr_fire_s;
   logic                 hdr_bad_s;
   logic                 blk_fire_s;
   logic                 disp_fire_s;
   logic                 reg_free_s;
   logic                 last_idx_s;
   logic                 blk_ready_s;
   logic [N_WORKERS-1:0] target_s;

   logic                 hdr_ready_r;
   logic                 busy_r;
   logic                 hdr_err_r;
   logic [N_WORKERS-1:0] disp_valid_r;
   logic [127:0]         disp_data_r;
   logic [CNT_W-1:0]     disp_counter_r;
   logic [2:0]           disp_phase_r;
   logic                 disp_new_r;
   logic                 disp_last_r;

   function automatic logic [2:0] phase_f(input logic [64:0] i, input logic [64:0] aad,
                                          input logic [64:0] pt, input logic [64:0] tot);
      logic [2:0] ph;
      if (i < aad) begin
         ph = 3'b010;
      end else if ((i == aad) && (pt == 65'd1)) begin
         ph = 3'b111;
      end else if ((i == (tot - 65'd1)) && (pt > 65'd1)) begin
         ph = 3'b011;
      end else if (i == aad) begin
         ph = 3'b000;
      end else begin
         ph = 3'b001;
      end
      return ph;
   endfunction

   assign aad_blk_s   = ({1'b0, i_hdr_aad_bits} + 65'd127) >> 7;
   assign pt_blk_s    = ({1'b0, i_hdr_pt_bits} + 65'd127) >> 7;
   assign tot_s       = aad_blk_s + pt_blk_s;
   assign hdr_bad_s   = (tot_s == 65'd0) || (tot_s > MAX_BLK_C);
   assign hdr_fire_s  = i_hdr_valid & hdr_ready_r;
   assign idx_ext_s   = {{(65-CNT_W){1'b0}}, idx_r};
   assign last_idx_s  = (idx_ext_s == (tot_r - 65'd1));
   assign disp_fire_s = |(disp_valid_r & i_disp_ready);
   assign reg_free_s  = ~(|disp_valid_r) | disp_fire_s;
   assign blk_fire_s  = i_blk_valid & blk_ready_s;

   // Round-robin target: low bits of the block index select the worker.
   always_comb begin
      target_s = {N_WORKERS{1'b0}};
      target_s[idx_r[SEL_W-1:0]] = 1'b1;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (hdr_fire_s) state_nxt_s = ST_CHECK;
            else            state_nxt_s = ST_IDLE;
         end
         ST_CHECK: begin
            if (hdr_err_r) state_nxt_s = ST_IDLE;
            else           state_nxt_s = ST_STREAM;
         end
         ST_STREAM: begin
            if (blk_fire_s && last_idx_s) state_nxt_s = ST_DRAIN;
            else                          state_nxt_s = ST_STREAM;
         end
         ST_DRAIN: begin
            if (reg_free_s) state_nxt_s = ST_IDLE;
            else            state_nxt_s = ST_DRAIN;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output decode: block ready only while streaming with room in the output register
   always_comb begin
      blk_ready_s = 1'b0;
      if (state_r == ST_STREAM) begin
         blk_ready_s = reg_free_s;
      end else begin
         blk_ready_s = 1'b0;
      end
   end

   // Registered status outputs, derived from the upcoming state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hdr_ready_r <= 1'b0;
         busy_r      <= 1'b0;
         hdr_err_r   <= 1'b0;
      end else begin
         hdr_ready_r <= (state_nxt_s == ST_IDLE);
         busy_r      <= (state_nxt_s != ST_IDLE);
         hdr_err_r   <= hdr_fire_s & hdr_bad_s;
      end
   end

   // Header latch and block index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aad_blk_r <= 65'd0;
         pt_blk_r  <= 65'd0;
         tot_r     <= 65'd0;
         iv_r      <= 96'd0;
         idx_r     <= {CNT_W{1'b0}};
      end else begin
         if (hdr_fire_s) begin
            aad_blk_r <= aad_blk_s;
            pt_blk_r  <= pt_blk_s;
            tot_r     <= tot_s;
            iv_r      <= i_hdr_iv;
         end
         if (state_r == ST_CHECK) begin
            idx_r <= {CNT_W{1'b0}};
         end else if (blk_fire_s) begin
            idx_r <= idx_r + CNT_W'(1);
         end
      end
   end

   // Output register: reload on input handshake, clear when the target worker takes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_valid_r   <= {N_WORKERS{1'b0}};
         disp_data_r    <= 128'd0;
         disp_counter_r <= {CNT_W{1'b0}};
         disp_phase_r   <= 3'b000;
         disp_new_r     <= 1'b0;
         disp_last_r    <= 1'b0;
      end else if (blk_fire_s) begin
         disp_valid_r   <= target_s;
         disp_data_r    <= i_blk_data;
         disp_counter_r <= idx_r;
         disp_phase_r   <= phase_f(idx_ext_s, aad_blk_r, pt_blk_r, tot_r);
         disp_new_r     <= (idx_r == {CNT_W{1'b0}});
         disp_last_r    <= last_idx_s;
      end else if (disp_fire_s) begin
         disp_valid_r   <= {N_WORKERS{1'b0}};
      end
   end

   assign o_hdr_ready         = hdr_ready_r;
   assign o_blk_ready         = blk_ready_s;
   assign o_busy              = busy_r;
   assign o_hdr_err           = hdr_err_r;
   assign o_disp_valid        = disp_valid_r;
   assign o_disp_data         = disp_data_r;
   assign o_disp_iv           = iv_r;
   assign o_disp_counter      = disp_counter_r;
   assign o_disp_phase        = disp_phase_r;
   assign o_disp_new_instance = disp_new_r;
   assign o_disp_last         = disp_last_r;

endmodule

// File: tb/tb_gcm_block_dispatcher.sv
// Directed bench for gcm_block_dispatcher: header table plus stall and mid-stream reset sequences.
module tb_gcm_block_dispatcher;

   localparam int NW = 4;
   localparam int CW = 17;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_hdr_valid;
   logic          o_hdr_ready;
   logic [63:0]   i_hdr_aad_bits;
   logic [63:0]   i_hdr_pt_bits;
   logic [95:0]   i_hdr_iv;
   logic          i_blk_valid;
   logic          o_blk_ready;
   logic [127:0]  i_blk_data;
   logic [NW-1:0] o_disp_valid;
   logic [NW-1:0] i_disp_ready;
   logic [127:0]  o_disp_data;
   logic [95:0]   o_disp_iv;
   logic [CW-1:0] o_disp_counter;
   logic [2:0]    o_disp_phase;
   logic          o_disp_new_instance;
   logic          o_disp_last;
   logic          o_busy;
   logic          o_hdr_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   gcm_block_dispatcher #(.N_WORKERS(NW), .MAX_BLOCKS(100000), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_hdr_valid(i_hdr_valid), .o_hdr_ready(o_hdr_ready),
      .i_hdr_aad_bits(i_hdr_aad_bits), .i_hdr_pt_bits(i_hdr_pt_bits), .i_hdr_iv(i_hdr_iv),
      .i_blk_valid(i_blk_valid), .o_blk_ready(o_blk_ready), .i_blk_data(i_blk_data),
      .o_disp_valid(o_disp_valid), .i_disp_ready(i_disp_ready),
      .o_disp_data(o_disp_data), .o_disp_iv(o_disp_iv), .o_disp_counter(o_disp_counter),
      .o_disp_phase(o_disp_phase), .o_disp_new_instance(o_disp_new_instance),
      .o_disp_last(o_disp_last), .o_busy(o_busy), .o_hdr_err(o_hdr_err)
   );

   // ph holds 3-bit phase codes, block 0 in bits [2:0]
   typedef struct {
      logic [63:0] aad;
      logic [63:0] pt;
      logic        err;
      int          n;
      logic [23:0] ph;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] bd(input int f, input int k);
      return {32'(f), 32'(k), 64'hA5A5_5A5A_DEAD_BEEF};
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_hdr_ready"}, o_hdr_ready, 1'b0);
      chk({tag, "_blk_ready"}, o_blk_ready, 1'b0);
      chk({tag, "_disp_valid"}, o_disp_valid, 4'b0000);
      chk({tag, "_disp_data"}, o_disp_data, 128'd0);
      chk({tag, "_disp_iv"}, o_disp_iv, 96'd0);
      chk({tag, "_counter"}, o_disp_counter, 17'd0);
      chk({tag, "_phase"}, o_disp_phase, 3'b000);
      chk({tag, "_new"}, o_disp_new_instance, 1'b0);
      chk({tag, "_last"}, o_disp_last, 1'b0);
      chk({tag, "_busy"}, o_busy, 1'b0);
      chk({tag, "_hdr_err"}, o_hdr_err, 1'b0);
   endtask

   // Starts and ends at a negedge. abort_at stops after that many dispatches.
   task automatic run_frame(input int fid, input logic [63:0] aad, input logic [63:0] pt,
                            input logic err, input int n, input logic [23:0] ph,
                            input int stall_w, input int stall_len, input int abort_at);
      logic [95:0] iv;
      int t, in_k, out_k, stall_seen, first, lastc, cyc;
      bit done;
      iv = {64'h0123_4567_89AB_CDEF, 32'(fid)};
      t = 0;
      while (o_hdr_ready !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("hdr_ready_idle", o_hdr_ready, 1'b1);
      @(posedge clk); #1;
      i_hdr_valid = 1'b1; i_hdr_aad_bits = aad; i_hdr_pt_bits = pt; i_hdr_iv = iv;
      i_blk_valid = 1'b0; i_disp_ready = 4'hF;
      @(posedge clk); #1;
      i_hdr_valid = 1'b0;
      if (err) begin
         @(negedge clk);
         chk("hdr_err_pulse", o_hdr_err, 1'b1);
         chk("hdr_ready_in_check", o_hdr_ready, 1'b0);
         chk("busy_in_check", o_busy, 1'b1);
         @(posedge clk); #1;
         @(negedge clk);
         chk("hdr_err_clear", o_hdr_err, 1'b0);
         chk("hdr_ready_back", o_hdr_ready, 1'b1);
         chk("busy_after_err", o_busy, 1'b0);
         chk("no_disp_on_err", o_disp_valid, 4'b0000);
         return;
      end
      in_k = 0; out_k = 0; stall_seen = 0; first = -1; lastc = -1; cyc = 0; done = 1'b0;
      while (!done && cyc < 80) begin
         i_blk_valid  = (in_k < n);
         i_blk_data   = bd(fid, in_k);
         i_disp_ready = (stall_len > 0 && stall_seen < stall_len) ? ~(4'b0001 << stall_w) : 4'hF;
         @(negedge clk);
         if (cyc == 0) begin
            chk("blk_ready_in_check", o_blk_ready, 1'b0);
            chk("busy_frame", o_busy, 1'b1);
            chk("hdr_err_good", o_hdr_err, 1'b0);
         end
         if (o_disp_valid !== 4'b0000) begin
            chk("extra_dispatch", (out_k < n), 1'b1);
            chk("disp_valid", o_disp_valid, 4'b0001 << (out_k % 4));
            chk("disp_data", o_disp_data, bd(fid, out_k));
            chk("disp_counter", o_disp_counter, 17'(out_k));
            chk("disp_phase", o_disp_phase, ph[3*out_k +: 3]);
            chk("disp_new", o_disp_new_instance, (out_k == 0));
            chk("disp_last", o_disp_last, (out_k == n - 1));
            chk("disp_iv", o_disp_iv, iv);
            if ((o_disp_valid & i_disp_ready) != 4'b0000) begin
               if (first < 0) first = cyc;
               lastc = cyc;
               out_k++;
            end else begin
               stall_seen++;
               chk("blk_ready_stall", o_blk_ready, 1'b0);
            end
         end
         if (i_blk_valid && o_blk_ready) in_k++;
         if (out_k == n || out_k == abort_at) begin
            done = 1'b1;
         end else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      chk("frame_timeout", done, 1'b1);
      if (!done || out_k == abort_at) return;
      chk("busy_last", o_busy, 1'b1);
      if (stall_len == 0) chk("one_per_cycle", lastc - first, n - 1);
      else                chk("stall_cycles", stall_seen, stall_len);
      @(posedge clk); #1;
      i_blk_valid = 1'b0;
      @(negedge clk);
      chk("busy_fall", o_busy, 1'b0);
      chk("hdr_ready_end", o_hdr_ready, 1'b1);
      chk("disp_idle", o_disp_valid, 4'b0000);
   endtask

   initial begin
      vecs[0] = '{aad: 64'd256, pt: 64'd384, err: 1'b0, n: 5,
                  ph: {9'd0, 3'b011, 3'b001, 3'b000, 3'b010, 3'b010}};
      vecs[1] = '{aad: 64'd0, pt: 64'd100, err: 1'b0, n: 1, ph: {21'd0, 3'b111}};
      vecs[2] = '{aad: 64'd200, pt: 64'd0, err: 1'b0, n: 2, ph: {18'd0, 3'b010, 3'b010}};
      vecs[3] = '{aad: 64'd0, pt: 64'd0, err: 1'b1, n: 0, ph: 24'd0};
      vecs[4] = '{aad: 64'd0, pt: 64'd12800128, err: 1'b1, n: 0, ph: 24'd0};
      vecs[5] = '{aad: 64'd1, pt: 64'd129, err: 1'b0, n: 3,
                  ph: {15'd0, 3'b011, 3'b000, 3'b010}};
      vecs[6] = '{aad: 64'hFFFF_FFFF_FFFF_FF81, pt: 64'd128, err: 1'b1, n: 0, ph: 24'd0};
      vecs[7] = '{aad: 64'd0, pt: 64'd128, err: 1'b0, n: 1, ph: {21'd0, 3'b111}};
      vecs[8] = '{aad: 64'd128, pt: 64'd512, err: 1'b0, n: 5,
                  ph: {9'd0, 3'b011, 3'b001, 3'b001, 3'b000, 3'b010}};
      vecs[9] = '{aad: 64'd0, pt: 64'd12800001, err: 1'b1, n: 0, ph: 24'd0};

      rst_n = 1'b0; i_hdr_valid = 1'b0; i_hdr_aad_bits = 64'd0; i_hdr_pt_bits = 64'd0;
      i_hdr_iv = 96'd0; i_blk_valid = 1'b0; i_blk_data = 128'd0; i_disp_ready = 4'hF;
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         run_frame(i, vecs[i].aad, vecs[i].pt, vecs[i].err, vecs[i].n, vecs[i].ph, 0, 0, 99);
      end

      // Worker 1 stalls 5 cycles on block 1; other workers stay ready
      run_frame(10, 64'd0, 64'd512, 1'b0, 4, {12'd0, 3'b011, 3'b001, 3'b001, 3'b000}, 1, 5, 99);

      // Reset in the middle of a 4-block frame, after 2 dispatches
      run_frame(20, 64'd0, 64'd512, 1'b0, 4, {12'd0, 3'b011, 3'b001, 3'b001, 3'b000}, 0, 0, 2);
      #1 rst_n = 1'b0;
      #1 chk_all_zero("midreset");
      i_blk_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      run_frame(21, 64'd0, 64'd256, 1'b0, 2, {18'd0, 3'b011, 3'b000}, 0, 0, 99);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gcm_block_dispatcher.md
Name: gcm_block_dispatcher

Overview:
- Front-end scheduler for the parallel AES-GCM encryption workers. Accepts one frame header at a time: AAD length, plaintext length and IV.
- Streams the frame's 128-bit blocks to N_WORKERS workers in strict round-robin order by block index. Tags each block with its in-frame counter, phase code, new-instance and last flags.
- Sits between the frame ingress buffer and the per-worker pipeline stage 1 inputs. It replaces the per-worker free-running counter/phase derivation with one central sequencer.

Parameters:
- N_WORKERS, 4, number of parallel encryption workers; power of two.
- MAX_BLOCKS, 100000, largest legal frame size in 128-bit blocks; 100000 is also the invalid-counter marker.
- CNT_W, 17, width of block counters; must be at least clog2(MAX_BLOCKS+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_hdr_valid  in  1  frame header offered
- o_hdr_ready  out  1  header accepted this cycle when both valid and ready are high
- i_hdr_aad_bits  in  64  AAD length in bits
- i_hdr_pt_bits  in  64  plaintext length in bits
- i_hdr_iv  in  96  frame IV
- i_blk_valid  in  1  data block offered
- o_blk_ready  out  1  data block accepted when both valid and ready are high
- i_blk_data  in  128  AAD or plaintext block, bit 0 = MSB
- o_disp_valid  out  N_WORKERS  one-hot; bit w means a block is addressed to worker w
- i_disp_ready  in  N_WORKERS  per-worker ready
- o_disp_data  out  128  block payload
- o_disp_iv  out  96  frame IV
- o_disp_counter  out  CNT_W  block index within frame, starting at 0
- o_disp_phase  out  3  phase code (see Behaviour)
- o_disp_new_instance  out  1  first block of the frame
- o_disp_last  out  1  final block of the frame
- o_busy  out  1  a frame is in progress
- o_hdr_err  out  1  one-cycle pulse when a header is rejected

Behaviour:
- Reset (asynchronous, rst_n low): state = IDLE; all outputs 0; internal counters 0; any in-flight block is discarded.
- Block counts use ceiling division:
  - aad_blk = (aad_bits + 127) >> 7
  - pt_blk = (pt_bits + 127) >> 7
  - tot = aad_blk + pt_blk
  - Compute in 65 bits before any range check.
- States:
  - IDLE: o_hdr_ready = 1. On header handshake, latch the header, go to CHECK.
  - CHECK (1 cycle): if tot == 0 or tot > MAX_BLOCKS, pulse o_hdr_err and return to IDLE. Otherwise set idx = 0 and go to STREAM.
  - STREAM: o_blk_ready = 1 when the output register is empty or is being accepted this cycle. Each accepted block loads the output register and increments idx. When the block with idx == tot-1 is accepted, go to DRAIN.
  - DRAIN: wait until the output register empties, then go to IDLE.
- o_busy = 1 in CHECK, STREAM and DRAIN.
- Output register:
  - Holds one block and is loaded on the cycle after the input handshake (latency 1).
  - Target worker is idx mod N_WORKERS (low bits of idx); o_disp_valid has only that bit set.
  - All o_disp_* fields stay stable while valid is high and the target's i_disp_ready is low.
  - Ready from non-target workers is ignored.
  - Accept and reload in the same cycle is allowed, giving 1 block/cycle throughput.
- Phase code, evaluated per block index i:
  - i < aad_blk: 3'b010 (AAD).
  - i == aad_blk and pt_blk == 1: 3'b111 (first and last text).
  - i == tot-1 and pt_blk > 1: 3'b011 (last text).
  - i == aad_blk: 3'b000 (first text).
  - Otherwise: 3'b001 (text).
  - The invalid code 3'b100 is never driven with valid high.
- Flags:
  - o_disp_new_instance = (i == 0).
  - o_disp_last = (i == tot-1), including AAD-only frames where pt_blk == 0.
- Output counter is zero-extended idx; no wrap inside a frame because tot ≤ MAX_BLOCKS.
- Headers are not accepted outside IDLE. Blocks are not accepted outside STREAM.
- An upstream block arriving before its header is simply stalled.

Test Plan:
- Header aad=256, pt=384 (2+3 blocks); 5 blocks; all ready -> 5 dispatches, one per cycle, workers 0,1,2,3,0; phases 010,010,000,001,011; new_instance on block 0; last on block 4; o_busy falls 1 cycle after the last accept.
- aad=0, pt=100 -> one block to worker 0 with phase 111, new_instance=1, last=1.
- aad=200, pt=0 -> two blocks, phases 010,010, last on idx 1.
- aad=0, pt=0, then pt=128*100001 -> o_hdr_err pulses twice, no dispatches, o_hdr_ready back to 1 after 2 cycles each.
- aad=0, pt=512; hold i_disp_ready[1]=0 for 5 cycles -> block 1 held stable for 5 cycles on worker 1; o_blk_ready low during the stall; ready on workers 0/2/3 has no effect.
- Assert rst_n low mid-STREAM after 2 of 4 blocks -> all outputs 0 immediately; the next header starts at idx 0 with new_instance=1.
